// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by alu_4bit, its BIST controller and the bench:
//   alu_op_e      - ALU opcode encoding (add, sub, and, or, xor)
//   bist_state_e  - BIST controller FSM states
//   alu_expected  - golden 5-bit {carry,result} for one ALU operation
//   fold_opcode   - folds a raw 3-bit value onto the five legal opcodes
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } bist_state_e;

  // Sub is done in 5 bits so bit 4 comes out as the borrow.
  function automatic logic [4:0] alu_expected(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input alu_op_e    op);
    logic [4:0] r;
    r = 5'h00;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Values 5..7 wrap back onto 0..2 so every vector uses a legal opcode.
  function automatic logic [2:0] fold_opcode(input logic [2:0] raw);
    return (raw >= 3'd5) ? raw - 3'd5 : raw;
  endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// ---------------------------------------------------------------------------
// alu_bist_lfsr
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
// The feedback bit l[15]^l[13]^l[12]^l[10] is shifted into bit 0.
// Ports:
//   clk    in   clock, all state on rising edge
//   rst_n  in   synchronous active-low reset (clears q)
//   load   in   load q from seed (wins over step)
//   seed   in   16-bit load value
//   step   in   advance one step
//   q      out  current register state
// ---------------------------------------------------------------------------
module alu_bist_lfsr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; the reset is synchronous, so it lives inside the
  // clocked branch instead of in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// ---------------------------------------------------------------------------
// alu_bist_ctrl
// Built-in self-test initiator for the combinational alu_4bit. Each vector
// is taken from an LFSR, registered onto the ALU inputs, allowed to settle,
// and the ALU's {carry,result} is compared with alu_expected().
// Parameters:
//   NUM_VECTORS    vectors per run, 1..255
//   SETTLE_CYCLES  idle cycles between drive and check, 0..15
//   LFSR_SEED      LFSR load value on start (0 is replaced by 16'h0001)
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   start            level-sampled in IDLE/DONE, begins a run
//   alu_a/b/opcode   registered ALU stimulus
//   alu_result/carry ALU response
//   busy             high from DRIVE of vector 0 through the last CHECK
//   done             high in DONE until the next start or reset
//   pass_cnt/fail_cnt saturating per-run vector counts
//   fail_seen        at least one failure this run
//   first_fail       {opcode,A,B,got[4:0]} of the first failing vector
// ---------------------------------------------------------------------------
module alu_bist_ctrl
  import alu_pkg::*;
#(
  parameter int          NUM_VECTORS   = 20,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_opcode,
  input  logic [3:0]  alu_result,
  input  logic        alu_carry,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pass_cnt,
  output logic [7:0]  fail_cnt,
  output logic        fail_seen,
  output logic [15:0] first_fail
);

  localparam logic [7:0]  VEC_LAST    = 8'(NUM_VECTORS - 1);
  localparam logic [3:0]  SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0
                                                             : 4'(SETTLE_CYCLES - 1);
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [15:0] SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  bist_state_e state_q, state_d;
  logic        do_load, do_drive, do_check;
  logic [15:0] lfsr_q;
  logic [7:0]  vec_cnt;
  logic [3:0]  settle_cnt;
  logic        last_vec;
  logic [4:0]  got, expected;
  logic        lfsr_unused;

  alu_bist_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (do_load),
    .seed  (SEED_EFF),
    .step  (do_drive),
    .q     (lfsr_q)
  );

  // Only bits [10:0] feed the vector; the upper bits only feed back.
  assign lfsr_unused = ^lfsr_q[15:11];

  assign last_vec = (vec_cnt == VEC_LAST);
  assign got      = {alu_carry, alu_result};
  assign expected = alu_expected(alu_a, alu_b, alu_op_e'(alu_opcode));
  assign busy     = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign done     = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    do_load  = 1'b0;
    do_drive = 1'b0;
    do_check = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          do_load = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        do_drive = 1'b1;
        state_d  = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        do_check = 1'b1;
        state_d  = last_vec ? DONE : DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (do_drive) begin
      settle_cnt <= '0;
    end else if (state_q == SETTLE) begin
      settle_cnt <= settle_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      vec_cnt    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else begin
      if (do_load) begin
        vec_cnt    <= '0;
        pass_cnt   <= '0;
        fail_cnt   <= '0;
        fail_seen  <= 1'b0;
        first_fail <= '0;
      end
      // The ALU inputs are held from here until the next DRIVE, so the
      // response is stable through SETTLE and CHECK.
      if (do_drive) begin
        alu_a      <= lfsr_q[3:0];
        alu_b      <= lfsr_q[7:4];
        alu_opcode <= fold_opcode(lfsr_q[10:8]);
      end
      if (do_check) begin
        if (got == expected) begin
          if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
        end else begin
          if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
          if (!fail_seen) begin
            first_fail <= {alu_opcode, alu_a, alu_b, got};
            fail_seen  <= 1'b1;
          end
        end
        if (!last_vec) vec_cnt <= vec_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_bist_ctrl
// Three controllers share clk/rst_n:
//   u_def  defaults (20 vectors, 1 settle cycle) on a bench ALU with
//          selectable faults; a per-cycle reference model follows it
//   u_min  1 vector, no settle, seed 0 (replaced by 1)
//   u_big  255 vectors, 2 settle cycles, ALU result stuck at 0
// The bench ALU and all expected values use plain arithmetic on the
// vector stream produced by a bench-side LFSR.
// ---------------------------------------------------------------------------
module tb_alu_bist_ctrl;
  import alu_pkg::*;

  localparam int DEF_N = 20;
  localparam int DEF_P = 3;      // 2 + SETTLE_CYCLES
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic       carry0;
    logic       res0;
    logic       use_bad;
    logic [3:0] bad_a;
    logic [4:0] mask;
  } fault_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  fault_t def_f = '0;
  fault_t min_f = '0;
  fault_t big_f = 11'b01_0_0000_00000;   // result stuck at 0

  logic start_def, start_min, start_big;
  logic [3:0]  def_a, def_b, def_result, min_a, min_b, min_result, big_a, big_b, big_result;
  logic [2:0]  def_op, min_op, big_op;
  logic        def_carry, min_carry, big_carry;
  logic        def_busy, def_done, def_fseen, min_busy, min_done, min_fseen;
  logic        big_busy, big_done, big_fseen;
  logic [7:0]  def_pass, def_fail, min_pass, min_fail, big_pass, big_fail;
  logic [15:0] def_ffirst, min_ffirst, big_ffirst;

  // ---- reference arithmetic ------------------------------------------------
  function automatic int ref_alu(input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] op);
    case (op)
      3'd0:    return int'(a) + int'(b);
      3'd1:    return (int'(a) - int'(b) + 32) % 32;
      3'd2:    return int'(a & b);
      3'd3:    return int'(a | b);
      3'd4:    return int'(a ^ b);
      default: return 0;
    endcase
  endfunction

  function automatic logic [4:0] bench_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op, input fault_t f);
    logic [4:0] g;
    g = 5'(ref_alu(a, b, op));
    if (f.carry0) g[4] = 1'b0;
    if (f.res0) g[3:0] = 4'h0;
    if (f.use_bad && a == f.bad_a) g = g ^ f.mask;
    return g;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic vec_t vec_from(input logic [15:0] l);
    vec_t v;
    v.a  = l[3:0];
    v.b  = l[7:4];
    v.op = 3'(int'(l[10:8]) % 5);
    return v;
  endfunction

  task automatic model_run(input logic [15:0] seed, input int n, input fault_t f,
                           output int pc, output int fc, output logic [15:0] ff);
    logic [15:0] l;
    vec_t v;
    logic [4:0] g;
    l = (seed == 16'h0) ? 16'h0001 : seed;
    pc = 0; fc = 0; ff = '0;
    for (int i = 0; i < n; i++) begin
      v = vec_from(l);
      g = bench_alu(v.a, v.b, v.op, f);
      if (int'(g) == ref_alu(v.a, v.b, v.op)) pc++;
      else begin
        if (fc == 0) ff = {v.op, v.a, v.b, g};
        fc++;
      end
      l = lfsr_next(l);
    end
    if (pc > 255) pc = 255;
    if (fc > 255) fc = 255;
  endtask

  // ---- DUTs and bench ALUs ---------------------------------------------------
  assign {def_carry, def_result} = bench_alu(def_a, def_b, def_op, def_f);
  assign {min_carry, min_result} = bench_alu(min_a, min_b, min_op, min_f);
  assign {big_carry, big_result} = bench_alu(big_a, big_b, big_op, big_f);

  alu_bist_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .start(start_def),
    .alu_a(def_a), .alu_b(def_b), .alu_opcode(def_op),
    .alu_result(def_result), .alu_carry(def_carry),
    .busy(def_busy), .done(def_done), .pass_cnt(def_pass), .fail_cnt(def_fail),
    .fail_seen(def_fseen), .first_fail(def_ffirst)
  );

  alu_bist_ctrl #(.NUM_VECTORS(1), .SETTLE_CYCLES(0), .LFSR_SEED(16'h0000)) u_min (
    .clk(clk), .rst_n(rst_n), .start(start_min),
    .alu_a(min_a), .alu_b(min_b), .alu_opcode(min_op),
    .alu_result(min_result), .alu_carry(min_carry),
    .busy(min_busy), .done(min_done), .pass_cnt(min_pass), .fail_cnt(min_fail),
    .fail_seen(min_fseen), .first_fail(min_ffirst)
  );

  alu_bist_ctrl #(.NUM_VECTORS(255), .SETTLE_CYCLES(2)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_big),
    .alu_a(big_a), .alu_b(big_b), .alu_opcode(big_op),
    .alu_result(big_result), .alu_carry(big_carry),
    .busy(big_busy), .done(big_done), .pass_cnt(big_pass), .fail_cnt(big_fail),
    .fail_seen(big_fseen), .first_fail(big_ffirst)
  );

  // ---- helpers ---------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts u_def, optionally holding/jittering start while busy, and
  // returns the number of edges from the start edge until done is seen.
  task automatic run_def(input int hold, input bit jitter, output int lat);
    start_def = 1'b1;
    lat = 0;
    tick();
    while (lat < 400) begin
      if (lat + 1 < hold)          start_def = 1'b1;
      else if (jitter && lat < 50) start_def = 1'($urandom_range(0, 1));
      else                         start_def = 1'b0;
      tick();
      lat++;
      if (def_done) break;
    end
    start_def = 1'b0;
  endtask

  // ---- per-cycle reference model and compare for u_def ------------------------
  // Inputs are driven 1 ns after a rising edge, so the values seen at a
  // falling edge are those the following rising edge samples.
  initial begin : cmp
    bit          valid, run, m_done, p_start, p_rst, fs;
    int          k, nchk, pc, fc;
    logic [3:0]  m_a, m_b;
    logic [2:0]  m_op;
    logic [15:0] l, ff;
    vec_t        vs[DEF_N];
    logic [4:0]  vg[DEF_N];
    bit          vok[DEF_N];
    valid = 0; run = 0; m_done = 0; p_start = 0; p_rst = 1;
    k = 0; nchk = 0; m_a = '0; m_b = '0; m_op = '0;
    forever begin
      @(negedge clk);
      if (!p_rst) begin
        valid = 1; run = 0; m_done = 0; nchk = 0;
        m_a = '0; m_b = '0; m_op = '0;
      end else if (valid && !run && p_start) begin
        l = SEED;
        for (int i = 0; i < DEF_N; i++) begin
          vs[i]  = vec_from(l);
          vg[i]  = bench_alu(vs[i].a, vs[i].b, vs[i].op, def_f);
          vok[i] = (int'(vg[i]) == ref_alu(vs[i].a, vs[i].b, vs[i].op));
          l = lfsr_next(l);
        end
        run = 1; m_done = 0; k = 0; nchk = 0;
      end else if (valid && run) begin
        k++;
        if ((k - 1) % DEF_P == 0) begin
          m_a  = vs[(k - 1) / DEF_P].a;
          m_b  = vs[(k - 1) / DEF_P].b;
          m_op = vs[(k - 1) / DEF_P].op;
        end
        nchk = k / DEF_P;
        if (k == DEF_N * DEF_P) begin
          run = 0; m_done = 1;
        end
      end
      if (valid) begin
        pc = 0; fc = 0; fs = 0; ff = '0;
        for (int j = 0; j < nchk; j++) begin
          if (vok[j]) pc++;
          else begin
            if (!fs) begin
              ff = {vs[j].op, vs[j].a, vs[j].b, vg[j]};
              fs = 1;
            end
            fc++;
          end
        end
        check("def.busy", 32'(def_busy), 32'(run));
        check("def.done", 32'(def_done), 32'(m_done));
        check("def.alu_in", 32'({def_a, def_b, def_op}), 32'({m_a, m_b, m_op}));
        check("def.pass_cnt", 32'(def_pass), pc);
        check("def.fail_cnt", 32'(def_fail), fc);
        check("def.fail_seen", 32'(def_fseen), 32'(fs));
        check("def.first_fail", 32'(def_ffirst), 32'(ff));
      end
      p_start = start_def;
      p_rst   = rst_n;
    end
  end

  // ---- stimulus ------------------------------------------------------------------
  initial begin : main
    int          lat, pc, fc, cnt;
    logic [15:0] ff, l;
    bit          found;
    vec_t        v;

    rst_n = 1'b0; start_def = 1'b0; start_min = 1'b0; start_big = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    check("rst.def_flags", 32'({def_busy, def_done, def_fseen}), 0);
    check("rst.def_cnts", 32'({def_pass, def_fail}), 0);
    check("rst.def_ff", 32'(def_ffirst), 0);
    check("rst.def_alu", 32'({def_a, def_b, def_op}), 0);
    check("rst.min_flags", 32'({min_busy, min_done, min_fseen, min_pass}), 0);
    check("rst.big_flags", 32'({big_busy, big_done, big_fseen, big_fail}), 0);

    // Golden function and bench-model pins.
    check("unit.add_F_1", 32'(alu_expected(4'hF, 4'h1, OP_ADD)), 32'h10);
    check("unit.sub_0_1", 32'(alu_expected(4'h0, 4'h1, OP_SUB)), 32'h1F);
    check("unit.xor_C_A", 32'(alu_expected(4'hC, 4'hA, OP_XOR)), 32'h06);
    check("unit.and_A_5", 32'(alu_expected(4'hA, 4'h5, OP_AND)), 32'h00);
    check("model.lfsr1", 32'(lfsr_next(SEED)), 32'h59C3);
    v = vec_from(SEED);
    check("model.vec0", 32'({v.a, v.b, v.op}), 32'({4'h1, 4'hE, 3'd4}));
    v = vec_from(16'h59C3);
    check("model.vec1", 32'({v.a, v.b, v.op}), 32'({4'h3, 4'hC, 3'd1}));
    check("model.sub_3_C", ref_alu(4'h3, 4'hC, 3'd1), 32'h17);

    // Clean run with a single-cycle start pulse.
    run_def(1, 0, lat);
    check("clean.latency", lat, 60);
    check("clean.pass_cnt", 32'(def_pass), 20);
    check("clean.fail", 32'({def_fseen, def_fail}), 0);

    // Carry stuck at 0: only add overflow and sub borrow vectors fail.
    def_f = '0;
    def_f.carry0 = 1'b1;
    run_def(1, 0, lat);
    l = SEED; cnt = 0; found = 0; ff = '0;
    for (int i = 0; i < DEF_N; i++) begin
      v = vec_from(l);
      if ((v.op == 3'd0 && int'(v.a) + int'(v.b) > 15) || (v.op == 3'd1 && v.a < v.b)) begin
        if (!found) ff = {v.op, v.a, v.b, 5'(ref_alu(v.a, v.b, v.op) & 15)};
        found = 1;
        cnt++;
      end
      l = lfsr_next(l);
    end
    check("carry0.latency", lat, 60);
    check("carry0.fail_cnt", 32'(def_fail), cnt);
    check("carry0.pass_cnt", 32'(def_pass), DEF_N - cnt);
    check("carry0.first_fail", 32'(def_ffirst), 32'(ff));
    check("carry0.fail_seen", 32'(def_fseen), 32'(found));

    // Random operand-dependent faults, start held and jittered while busy.
    for (int r = 0; r < 4; r++) begin
      def_f = '0;
      def_f.use_bad = 1'b1;
      def_f.bad_a   = 4'($urandom_range(0, 15));
      def_f.mask    = 5'($urandom_range(1, 31));
      model_run(SEED, DEF_N, def_f, pc, fc, ff);
      run_def($urandom_range(1, 40), 1, lat);
      check("rand.latency", lat, 60);
      check("rand.fail_cnt", 32'(def_fail), fc);
      check("rand.first_fail", 32'(def_ffirst), 32'(ff));
    end

    // Reset while vector 7 is in SETTLE, then a clean rerun.
    def_f = '0;
    start_def = 1'b1;
    tick();
    start_def = 1'b0;
    repeat (22) tick();
    check("midrst.busy_before", 32'(def_busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst.flags", 32'({def_busy, def_done, def_fseen}), 0);
    check("midrst.cnts", 32'({def_pass, def_fail}), 0);
    check("midrst.alu", 32'({def_a, def_b, def_op}), 0);
    check("midrst.ff", 32'(def_ffirst), 0);
    run_def(1, 0, lat);
    check("after_rst.latency", lat, 60);
    check("after_rst.pass_cnt", 32'(def_pass), 20);

    // One vector, no settle, seed 0 -> vector from seed 1: 1 + 0.
    start_min = 1'b1;
    tick();
    start_min = 1'b0;
    check("min.done_e0", 32'({min_busy, min_done}), 32'b10);
    tick();
    check("min.done_e1", 32'({min_busy, min_done}), 32'b10);
    tick();
    check("min.done_e2", 32'({min_busy, min_done}), 32'b01);
    check("min.cnts", 32'({min_pass, min_fail}), 32'h0100);
    check("min.alu", 32'({min_a, min_b, min_op}), 32'({4'h1, 4'h0, 3'd0}));

    // 255 vectors against a result stuck at 0.
    model_run(SEED, 255, big_f, pc, fc, ff);
    start_big = 1'b1;
    tick();
    start_big = 1'b0;
    lat = 0;
    while (lat < 3000 && !big_done) begin
      tick();
      lat++;
    end
    check("big.latency", lat, 1020);
    check("big.fail_cnt", 32'(big_fail), fc);
    check("big.pass_cnt", 32'(big_pass), pc);
    check("big.first_fail", 32'(big_ffirst), 32'(ff));
    check("big.fail_seen", 32'(big_fseen), 32'(fc != 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
